// File: rtl/sync_modn_counter.sv
// Cascaded DIGITS x mod-MODULUS up/down counter with clamped parallel load, carry and sticky wrap flag.
// Latency: 1 edge per step or load; no backpressure, advances every cycle en is high.
module sync_modn_counter #(
    parameter int MODULUS = 10,
    parameter int WIDTH   = 4,
    parameter int DIGITS  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      up_dn,
    input  logic                      load,
    input  logic [DIGITS*WIDTH-1:0]   load_val,
    output logic [DIGITS*WIDTH-1:0]   q,
    output logic                      carry_out,
    output logic                      wrapped
);

    localparam logic [WIDTH-1:0] MAXD = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [DIGITS:0]            lower_max;
    logic [DIGITS:0]            lower_zero;
    logic [DIGITS*WIDTH-1:0]    q_step;
    logic [DIGITS*WIDTH-1:0]    q_load;
    logic [WIDTH-1:0]           dig;
    logic [WIDTH-1:0]           lv;
    logic                       terminal;

    // lower_max[i]/lower_zero[i]: every digit below i sits at its up/down terminal value
    always_comb begin
        lower_max     = '0;
        lower_zero    = '0;
        q_step        = '0;
        q_load        = '0;
        dig           = '0;
        lv            = '0;
        lower_max[0]  = 1'b1;
        lower_zero[0] = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            dig             = q[i*WIDTH +: WIDTH];
            lv              = load_val[i*WIDTH +: WIDTH];
            lower_max[i+1]  = lower_max[i] & (dig == MAXD);
            lower_zero[i+1] = lower_zero[i] & (dig == ZERO);
            if (up_dn && lower_max[i])
                q_step[i*WIDTH +: WIDTH] = (dig == MAXD) ? ZERO : dig + ONE;
            else if (!up_dn && lower_zero[i])
                q_step[i*WIDTH +: WIDTH] = (dig == ZERO) ? MAXD : dig - ONE;
            else
                q_step[i*WIDTH +: WIDTH] = dig;
            q_load[i*WIDTH +: WIDTH] = (lv > MAXD) ? MAXD : lv;
        end
    end

    assign terminal  = up_dn ? lower_max[DIGITS] : lower_zero[DIGITS];
    assign carry_out = en & ~load & ~reset & terminal;

    always_ff @(posedge clk) begin
        if (reset) begin
            q       <= '0;
            wrapped <= 1'b0;
        end else if (load) begin
            q       <= q_load;
            wrapped <= 1'b0;
        end else if (en) begin
            q       <= q_step;
            if (terminal)
                wrapped <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sync_modn_counter.sv
// Directed bench for sync_modn_counter: default 2-digit decimal instance plus a single-digit mod-6 instance.
module tb_sync_modn_counter;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // default instance (10/4/2)
    logic       reset, en, up_dn, load;
    logic [7:0] load_val;
    logic [7:0] q;
    logic       carry_out, wrapped;

    // mod-6 single-digit instance
    logic       s_reset, s_en, s_up_dn, s_load;
    logic [2:0] s_load_val;
    logic [2:0] s_q;
    logic       s_carry_out, s_wrapped;

    int passed = 0;
    int total  = 0;

    sync_modn_counter dut (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .q(q), .carry_out(carry_out), .wrapped(wrapped)
    );

    sync_modn_counter #(.MODULUS(6), .WIDTH(3), .DIGITS(1)) dut6 (
        .clk(clk), .reset(s_reset), .en(s_en), .up_dn(s_up_dn), .load(s_load),
        .load_val(s_load_val), .q(s_q), .carry_out(s_carry_out), .wrapped(s_wrapped)
    );

    typedef struct {
        logic       reset;
        logic       en;
        logic       up_dn;
        logic       load;
        logic [7:0] load_val;
        logic       exp_c;
        logic [7:0] exp_q;
        logic       exp_w;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic e, input logic u, input logic l,
                                input logic [7:0] lv, input logic c, input logic [7:0] eq,
                                input logic w);
        vec_t v;
        v.reset = r; v.en = e; v.up_dn = u; v.load = l; v.load_val = lv;
        v.exp_c = c; v.exp_q = eq; v.exp_w = w;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Inputs change just after a falling edge; carry is sampled before the rising edge, q/wrapped after it.
    task automatic step(input vec_t v, input string name);
        reset = v.reset; en = v.en; up_dn = v.up_dn; load = v.load; load_val = v.load_val;
        #1;
        check({name, ".carry"}, {31'd0, carry_out}, {31'd0, v.exp_c});
        @(posedge clk); #1;
        check({name, ".q"}, {24'd0, q}, {24'd0, v.exp_q});
        check({name, ".wrapped"}, {31'd0, wrapped}, {31'd0, v.exp_w});
        @(negedge clk);
    endtask

    task automatic sstep(input logic r, input logic e, input logic u, input logic l,
                         input logic [2:0] lv, input logic c, input logic [2:0] eq,
                         input logic w, input string name);
        s_reset = r; s_en = e; s_up_dn = u; s_load = l; s_load_val = lv;
        #1;
        check({name, ".carry"}, {31'd0, s_carry_out}, {31'd0, c});
        @(posedge clk); #1;
        check({name, ".q"}, {29'd0, s_q}, {29'd0, eq});
        check({name, ".wrapped"}, {31'd0, s_wrapped}, {31'd0, w});
        @(negedge clk);
    endtask

    initial begin
        int n;
        logic [7:0] eq;
        reset = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
        s_reset = 1'b1; s_en = 1'b0; s_up_dn = 1'b1; s_load = 1'b0; s_load_val = '0;
        @(negedge clk);

        //                r  e  u  l  load_val c  exp_q  w
        vecs.push_back(mk(1, 1, 0, 0, 8'h00,   0, 8'h00, 0)); // reset masks carry at q=00 down
        vecs.push_back(mk(0, 1, 0, 1, 8'h20,   0, 8'h20, 0)); // load beats en
        vecs.push_back(mk(0, 1, 0, 0, 8'h00,   0, 8'h19, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00,   0, 8'h18, 0));
        vecs.push_back(mk(0, 0, 0, 1, 8'h00,   0, 8'h00, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00,   1, 8'h99, 1)); // down wrap
        vecs.push_back(mk(0, 0, 0, 1, 8'h5C,   0, 8'h59, 0)); // digit 0 clamp
        vecs.push_back(mk(0, 0, 0, 1, 8'hA3,   0, 8'h93, 0)); // digit 1 clamp
        vecs.push_back(mk(0, 0, 1, 1, 8'hFF,   0, 8'h99, 0));
        vecs.push_back(mk(0, 1, 1, 1, 8'h99,   0, 8'h99, 0)); // load masks carry
        vecs.push_back(mk(0, 1, 1, 0, 8'h00,   1, 8'h00, 1)); // up wrap
        vecs.push_back(mk(0, 0, 1, 0, 8'h00,   0, 8'h00, 1)); // sticky, hold
        vecs.push_back(mk(0, 1, 1, 1, 8'h42,   0, 8'h42, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 0, 1, 0, 8'h00, 0, 8'h42, 0));
        vecs.push_back(mk(0, 1, 1, 0, 8'h00,   0, 8'h43, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00,   0, 8'h42, 0)); // direction flip, no settling
        vecs.push_back(mk(0, 0, 1, 1, 8'h37,   0, 8'h37, 0));
        vecs.push_back(mk(1, 1, 1, 1, 8'h55,   0, 8'h00, 0)); // reset beats load and en
        vecs.push_back(mk(0, 1, 1, 0, 8'h00,   0, 8'h01, 0));

        foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

        // Full 100-edge up-count from reset against a decimal model
        step(mk(1, 0, 1, 0, 8'h00, 0, 8'h00, 0), "seq_reset");
        n = 0;
        for (int k = 0; k < 100; k++) begin
            eq = {4'((n + 1) % 100 / 10), 4'((n + 1) % 10)};
            step(mk(0, 1, 1, 0, 8'h00, (n == 99), eq, (k == 99)), $sformatf("up%0d", k));
            n = (n + 1) % 100;
        end

        // Mod-6 single digit
        sstep(1, 0, 1, 0, 3'd0, 0, 3'd0, 0, "m6_reset");
        for (int k = 0; k < 6; k++)
            sstep(0, 1, 1, 0, 3'd0, (k == 5), 3'((k + 1) % 6), (k == 5), $sformatf("m6_up%0d", k));
        sstep(0, 1, 0, 0, 3'd0, 1, 3'd5, 1, "m6_down_wrap");
        sstep(0, 0, 1, 1, 3'd7, 0, 3'd5, 0, "m6_clamp7");
        sstep(0, 0, 1, 1, 3'd6, 0, 3'd5, 0, "m6_clamp6");
        sstep(0, 1, 0, 0, 3'd0, 0, 3'd4, 0, "m6_down");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
